shared_ram_arbiter: RTL and testbench
=====================================

Name: shared_ram_arbiter

Overview:
- Arbitrates one single-port synchronous work RAM between two emulated CPU buses: A (main CPU) and B (sub CPU).
- Emulates the board's TTL bus-arbitration logic. The losing CPU is stalled through its wait output until its access completes.
- Sits between the two CPU cores and the shared RAM. All timing is paced by the same one-cycle clock-enable strobes that drive the board's TTL flip-flop models.

Parameters:
- AW, 11, address width.
- DW, 8, data width.
- ACC_CYC, 2, number of cen strobes per RAM access; legal range 2..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  access-pacing strobe, one clk cycle wide.
- req_a  in  1  bus A access request, level.
- we_a  in  1  bus A write, 1 = write.
- addr_a  in  AW  bus A address.
- din_a  in  DW  bus A write data.
- dout_a  out  DW  bus A read data, registered.
- ack_a  out  1  bus A access complete, one-cycle pulse.
- wait_a  out  1  bus A stall.
- req_b, we_b, addr_b, din_b, dout_b, ack_b, wait_b: same as the A signals, for bus B.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data; the RAM has 1 clk read latency.

Behaviour:

Reset and clocking:
- Reset is asynchronous and active-low (rst_n).
- On reset: state=IDLE, all outputs 0, served_a=served_b=0, last=B (so A wins the first tie).
- All other logic is clocked on posedge clk.

State machine (states IDLE, ACC_A, ACC_B):
- pend_x = req_x & ~served_x.
- IDLE:
  - If pend_a & pend_b: grant the requester that is not "last".
  - Else grant whichever is pending.
  - Grant takes effect on the next clk edge, whether or not cen is high.
- On grant:
  - Latch we/addr/din of the winner into ram_addr/ram_din and an internal we register.
  - Clear the cycle counter.
  - Set last = winner.
  - Enter ACC_x.
- ACC_x:
  - Counter increments only on clk cycles with cen=1.
  - When cen=1 and counter==ACC_CYC-1 (the final strobe):
    - ram_we=1 for that single clk cycle if the latched we=1.
    - dout_x <= ram_dout if the latched we=0.
    - ack_x=1 on the following clk cycle.
    - served_x set, state returns to IDLE.
  - ram_addr/ram_din stay stable for the whole access.
- Latency from grant to ack: ACC_CYC cen strobes plus 1 clk.

Served and wait:
- served_x clears on any clk cycle with req_x=0. A requester therefore gets exactly one ack per req assertion, and must drop req for at least 1 clk before issuing a new access.
- wait_x = pend_x & ~ack_x, combinational. It is high from the request cycle until the ack cycle, including the whole time the other bus is being served.
- ram_we is 0 outside the final-strobe cycle.
- dout_x holds its value until that bus's next completed read.

Boundary conditions:
- Simultaneous requests in IDLE: round-robin via last. Continuous contention strictly alternates A, B, A, B.
- A request arriving during the other bus's access waits. It is granted in IDLE on the cycle after the other bus's ack, no extra idle cycle.
- Requester drops req mid-access: the access still completes, ram_we still fires, and ack is still pulsed. served_x is cleared on the ack cycle since req_x=0.
- cen held low: the access freezes with outputs stable. No timeout.
- Address/data changes on the bus after grant: ignored until the next grant.
- Reset mid-access: the access is aborted immediately and no ram_we is issued. After release, arbitration restarts with A priority.

Test Plan:
- Single read: RAM[0x123]=0x5A, ACC_CYC=2, cen every 4 clk, req_a with we_a=0. Required: ram_we never asserted; dout_a=0x5A; ack_a pulses exactly once, 1 clk after the 2nd cen of the access; wait_a=1 until the ack cycle.
- Single write: req_b, addr_b=0x7FF, din_b=0xC3. Required: exactly one ram_we pulse with ram_addr=0x7FF and ram_din=0xC3; subsequent read of 0x7FF by A returns 0xC3.
- Simultaneous requests from reset: req_a and req_b rise on the same cycle. Required: A served first; B granted the cycle after ack_a; wait_b stays high until ack_b. Repeat 4 rounds with both req held high (re-toggled after each ack) and check grant order A, B, A, B.
- Held request: keep req_a high for 20 clk after ack_a. Required: no second ack_a, no second RAM access; after req_a falls for 1 clk and rises again, a new access occurs.
- Mid-access abort: assert rst_n=0 during ACC_A before the final cen. Required: all outputs 0 immediately, no ram_we; after release, a tie with B resolves to A.
- cen stall: hold cen=0 for 50 clk mid-access. Required: ram_addr/ram_din stable, no ack, wait_a=1; completion occurs on the ACC_CYC-th cen overall.

Source files
------------

// File: rtl/shared_ram_arbiter.sv
// Two-master arbiter for a single-port synchronous work RAM, modelling the
// board's TTL bus-arbitration logic. Accesses are paced by the cen strobe.
module shared_ram_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int ACC_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  // bus A (main CPU)
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  output logic          ack_a,
  output logic          wait_a,
  // bus B (sub CPU)
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] dout_b,
  output logic          ack_b,
  output logic          wait_b,
  // shared RAM
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  // arbiter state: 0 = IDLE, 1 = ACC_A, 2 = ACC_B
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_A = 2'd1,
    ACC_B = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACC_CYC - 1);

  state_t        state_q;
  logic          last_q;      // 1 = bus B held the most recent grant
  logic          served_a_q;
  logic          served_b_q;
  logic          served_a_d;
  logic          served_b_d;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] dout_a_q;
  logic [DW-1:0] dout_b_q;
  logic          ack_a_q;
  logic          ack_b_q;

  logic pend_a;
  logic pend_b;
  logic grant_a;
  logic grant_b;
  logic final_strobe;
  logic final_a;
  logic final_b;

  assign pend_a = req_a & ~served_a_q;
  assign pend_b = req_b & ~served_b_q;

  // On a tie the bus that was not granted last wins.
  assign grant_a = (state_q == IDLE) & pend_a & (~pend_b | last_q);
  assign grant_b = (state_q == IDLE) & pend_b & (~pend_a | ~last_q);

  assign final_strobe = (state_q != IDLE) & cen & (cnt_q == LAST_CNT);
  assign final_a      = final_strobe & (state_q == ACC_A);
  assign final_b      = final_strobe & (state_q == ACC_B);

  // A bus stays served until it drops its request, giving one ack per req.
  always_comb begin
    served_a_d = 1'b0;
    served_b_d = 1'b0;
    if (req_a) served_a_d = served_a_q | final_a;
    if (req_b) served_b_d = served_b_q | final_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      served_a_q <= 1'b0;
      served_b_q <= 1'b0;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      ack_a_q    <= final_a;
      ack_b_q    <= final_b;
      served_a_q <= served_a_d;
      served_b_q <= served_b_d;
      case (state_q)
        IDLE: begin
          if (grant_a) begin
            state_q <= ACC_A;
            we_q    <= we_a;
            addr_q  <= addr_a;
            din_q   <= din_a;
            cnt_q   <= 4'd0;
            last_q  <= 1'b0;
          end else if (grant_b) begin
            state_q <= ACC_B;
            we_q    <= we_b;
            addr_q  <= addr_b;
            din_q   <= din_b;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
          end
        end
        ACC_A, ACC_B: begin
          if (cen) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= IDLE;
              // ram_addr has been stable since grant, so ram_dout is valid here.
              if (!we_q && state_q == ACC_A) dout_a_q <= ram_dout;
              if (!we_q && state_q == ACC_B) dout_b_q <= ram_dout;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
  assign ram_we    = final_strobe & we_q;
  assign dout_a    = dout_a_q;
  assign dout_b    = dout_b_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign wait_a    = pend_a & ~ack_a_q;
  assign wait_b    = pend_b & ~ack_b_q;
  assign dbg_state = state_q;

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(ack_a_q && ack_b_q));
  a_we_in_access: assert property (@(posedge clk) disable iff (!rst_n)
    ram_we |-> (state_q != IDLE));
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE && !final_strobe) |=> ($stable(addr_q) && $stable(din_q)));

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: RAM model, cen generator, table-driven
// accesses, multi-cycle corner sequences and an ack-driven scoreboard.
module tb_shared_ram_arbiter;

  localparam int AW      = 11;
  localparam int DW      = 8;
  localparam int ACC_CYC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;
  logic [DW-1:0] dout_a, dout_b;
  logic          ack_a, ack_b, wait_a, wait_b;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [1:0]    dbg_state;

  shared_ram_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a), .ack_a(ack_a), .wait_a(wait_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b), .ack_b(ack_b), .wait_b(wait_b),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cen ----------------
  always #5 clk = ~clk;

  bit cen_en = 1'b1;
  int phase = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      phase = (phase + 1) % 4;
      cen = cen_en && (phase == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (1 clk read latency) ----------------
  logic [DW-1:0] mem    [0:2047];
  logic [DW-1:0] shadow [0:2047];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard entry: {bus, is_read, data}
  logic [9:0] exp_q[$];

  int         cyc = 0;
  int         cens_since_grant = 0;
  int         last_cen_cyc = 0;
  logic [1:0] prev_state = 2'd0;
  int         we_cnt = 0;
  logic [AW-1:0] last_w_addr = '0;
  logic [DW-1:0] last_w_data = '0;
  int         ack_cnt_a = 0, ack_cnt_b = 0, grant_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [9:0] e;
    if (ack_a || ack_b) begin
      chk("ack_onehot", 32'(ack_a & ack_b), 32'd0);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_bus", 32'(ack_b), 32'(e[9]));
        if (e[8]) chk("sb_dout", 32'(ack_b ? dout_b : dout_a), 32'(e[7:0]));
      end
      chk("ack_cens", cens_since_grant, ACC_CYC);
      chk("ack_after_cen", cyc - last_cen_cyc, 1);
      if (ack_a) ack_cnt_a++;
      if (ack_b) ack_cnt_b++;
    end
    if (ram_we) begin
      we_cnt++;
      last_w_addr = ram_addr;
      last_w_data = ram_din;
    end
    if (dbg_state != 2'd0 && prev_state == 2'd0) begin
      cens_since_grant = 0;
      grant_cnt++;
    end
    if (dbg_state != 2'd0 && cen) begin
      cens_since_grant++;
      last_cen_cyc = cyc;
    end
    prev_state = dbg_state;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit bus, output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus ? ack_b : ack_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_any_ack(output bit got, output bit bus);
    got = 1'b0;
    bus = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        got = 1'b1;
        bus = ack_b;
        break;
      end
    end
    if (!got) chk("any_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_req(input bit bus, input bit v);
    if (!bus) req_a = v;
    else      req_b = v;
  endtask

  // One full access on one bus; bus inputs are scrambled after grant.
  task automatic do_access(input bit bus, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] exp);
    int we0;
    bit got;
    we0 = we_cnt;
    exp_q.push_back({bus, ~we, we ? 8'h00 : exp});
    if (we) shadow[addr] = data;
    @(posedge clk); #1;
    if (!bus) begin we_a = we; addr_a = addr; din_a = data; end
    else      begin we_b = we; addr_b = addr; din_b = data; end
    set_req(bus, 1'b1);
    @(negedge clk);
    chk("wait_on_req", 32'(bus ? wait_b : wait_a), 32'd1);
    @(posedge clk); #1;
    if (!bus) begin addr_a = ~addr; din_a = ~data; we_a = ~we; end
    else      begin addr_b = ~addr; din_b = ~data; we_b = ~we; end
    wait_ack(bus, got);
    @(posedge clk); #1;
    set_req(bus, 1'b0);
    if (we) begin
      chk("write_pulses", we_cnt - we0, 1);
      chk("write_addr", 32'(last_w_addr), 32'(addr));
      chk("write_data", 32'(last_w_data), 32'(data));
    end else begin
      chk("read_no_we", we_cnt - we0, 0);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit            bus;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    bit got, bus;
    int a0, g0, w0;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    bit stable;

    vecs[0] = '{1'b0, 1'b0, 11'h123, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 11'h7FF, 8'hC3, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 11'h7FF, 8'h00, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 11'h000, 8'h01, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 11'h000, 8'h00, 8'h01};
    vecs[5] = '{1'b1, 1'b1, 11'h400, 8'hA5, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 11'h400, 8'h00, 8'hA5};
    vecs[7] = '{1'b1, 1'b0, 11'h123, 8'h00, 8'h5A};

    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    mem[11'h123] = 8'h5A; shadow[11'h123] = 8'h5A;
    mem[11'h010] = 8'h11; shadow[11'h010] = 8'h11;
    mem[11'h020] = 8'h22; shadow[11'h020] = 8'h22;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    chk("rst_ack_a", 32'(ack_a), 32'd0);
    chk("rst_ack_b", 32'(ack_b), 32'd0);
    chk("rst_wait_a", 32'(wait_a), 32'd0);
    chk("rst_wait_b", 32'(wait_b), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // simultaneous requests from reset, then strict alternation
    for (int k = 0; k < 8; k++)
      exp_q.push_back({k[0], 1'b1, k[0] ? 8'h22 : 8'h11});
    @(posedge clk); #1;
    addr_a = 11'h010; we_a = 1'b0;
    addr_b = 11'h020; we_b = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_any_ack(got, bus);
      chk("alt_order", 32'(bus), 32'(k % 2));
      if (k == 0) chk("alt_wait_b_at_ack_a", 32'(wait_b), 32'd1);
      @(posedge clk); #1;
      set_req(bus, 1'b0);
      @(negedge clk);
      if (k == 0) chk("alt_b_granted_next", 32'(dbg_state), 32'd2);
      @(posedge clk); #1;
      if (k < 6) set_req(bus, 1'b1);
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);

    // table-driven single accesses
    for (int i = 0; i < 8; i++)
      do_access(vecs[i].bus, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp);

    // held request: one ack per req assertion
    a0 = ack_cnt_a; g0 = grant_cnt;
    exp_q.push_back({1'b0, 1'b1, 8'h5A});
    @(posedge clk); #1;
    we_a = 1'b0; addr_a = 11'h123; req_a = 1'b1;
    wait_ack(1'b0, got);
    repeat (20) @(posedge clk);
    #1;
    chk("held_single_ack", ack_cnt_a - a0, 1);
    chk("held_single_grant", grant_cnt - g0, 1);
    req_a = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b1, 8'h5A});
    req_a = 1'b1;
    wait_ack(1'b0, got);
    @(posedge clk); #1;
    req_a = 1'b0;
    chk("held_reissue_ack", ack_cnt_a - a0, 2);
    @(posedge clk); #1;

    // cen stall mid-access
    exp_q.push_back({1'b0, 1'b1, 8'h5A});
    we_a = 1'b0; addr_a = 11'h123; din_a = 8'h77; req_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd1 && cen) begin got = 1'b1; break; end
    end
    chk("stall_first_cen_seen", 32'(got), 32'd1);
    cen_en = 1'b0;
    r_addr = ram_addr; r_din = ram_din;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ram_addr !== r_addr || ram_din !== r_din || ack_a !== 1'b0 ||
          wait_a !== 1'b1 || ram_we !== 1'b0) stable = 1'b0;
    end
    chk("stall_frozen", 32'(stable), 32'd1);
    chk("stall_addr", 32'(r_addr), 32'h123);
    cen_en = 1'b1;
    wait_ack(1'b0, got);
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a write on A
    w0 = we_cnt;
    we_a = 1'b1; addr_a = 11'h055; din_a = 8'hEE; req_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd1) begin got = 1'b1; break; end
    end
    chk("abort_granted", 32'(got), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_ram_we", 32'(ram_we), 32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_ram_din", 32'(ram_din), 32'd0);
    chk("abort_dout_a", 32'(dout_a), 32'd0);
    chk("abort_ack_a", 32'(ack_a), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", we_cnt - w0, 0);
    we_a = 1'b0; addr_a = 11'h055;
    we_b = 1'b0; addr_b = 11'h020; req_b = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    exp_q.push_back({1'b1, 1'b1, 8'h22});
    @(negedge clk);
    rst_n = 1'b1;
    wait_any_ack(got, bus);
    chk("abort_tie_a_first", 32'(bus), 32'd0);
    @(posedge clk); #1;
    req_a = 1'b0;
    wait_ack(1'b1, got);
    @(posedge clk); #1;
    req_b = 1'b0;
    @(posedge clk); #1;

    // random accesses against the shadow memory
    for (int i = 0; i < 6; i++) begin
      bit            rb, rw;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      rb = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ra = 11'($urandom_range(0, 2047));
      rd = 8'($urandom_range(0, 255));
      do_access(rb, rw, ra, rd, shadow[ra]);
      if (rw) do_access(~rb, 1'b0, ra, 8'h00, rd);
    end

    repeat (4) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
